// File: rtl/leg_pc_ctrl.sv
// Program-counter and call/return controller for the 8-bit LEG core; drives the hardware call stack.
// Latency: pc/depth/fault update on the accept edge; stack strobes are combinational in the accept cycle.
// Backpressure: op_ready drops for one bubble after a taken RET and stays low in FAULT until reset.
module leg_pc_ctrl #(
    parameter int ADDR_W = 8,
    parameter int STEP   = 4,
    parameter int DEPTH  = 256,
    localparam int DW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [ADDR_W-1:0] stk_value,
    input  logic [ADDR_W-1:0] stk_top,
    output logic [DW-1:0]     depth,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam logic [1:0] OP_NEXT = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_OVF  = 2'b01;
    localparam logic [1:0] CODE_UNF  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic                fault_q, fault_d;
    logic [1:0]          fault_code_q, fault_code_d;

    logic                run;
    logic                accept;
    logic                is_jump;
    logic                is_call;
    logic                is_ret;
    logic                full;
    logic                empty;
    logic                ovf;
    logic                unf;
    logic [ADDR_W-1:0]   ret_addr;

    // Decode the offered operation; a not-taken JUMP/CALL/RET falls through as NEXT
    always_comb begin
        run      = (state_q == ST_RUN);
        accept   = op_valid & run;
        is_jump  = accept & cond & (op == OP_JUMP);
        is_call  = accept & cond & (op == OP_CALL);
        is_ret   = accept & cond & (op == OP_RET);
        full     = (depth_q == DW'(DEPTH));
        empty    = (depth_q == '0);
        ovf      = is_call & full;
        unf      = is_ret & empty;
        ret_addr = pc_q + ADDR_W'(STEP);
    end

    // State register plus datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pc_q         <= '0;
            depth_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= CODE_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            depth_q      <= depth_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state: a trap parks in FAULT, a successful RET buys one settle cycle for stack Top
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ovf || unf) begin
                    state_d = ST_FAULT;
                end else if (is_ret) begin
                    state_d = ST_RET_WAIT;
                end
            end
            ST_RET_WAIT: state_d = ST_RUN;
            ST_FAULT:    state_d = ST_FAULT;
            default:     state_d = ST_RUN;
        endcase
    end

    // Next PC, depth and trap flags; everything holds unless an operation is accepted
    always_comb begin
        pc_d         = pc_q;
        depth_d      = depth_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        if (accept) begin
            if (ovf) begin
                fault_d      = 1'b1;
                fault_code_d = CODE_OVF;
            end else if (unf) begin
                fault_d      = 1'b1;
                fault_code_d = CODE_UNF;
            end else if (is_call) begin
                pc_d    = target;
                depth_d = depth_q + DW'(1);
            end else if (is_ret) begin
                pc_d    = stk_top;
                depth_d = depth_q - DW'(1);
            end else if (is_jump) begin
                pc_d = target;
            end else begin
                pc_d = ret_addr;
            end
        end
    end

    // Outputs: stack strobes are gated by reset so the stack never moves while we are held
    always_comb begin
        op_ready   = run;
        stk_push   = rst & is_call & ~full;
        stk_pop    = rst & is_ret & ~empty;
        stk_value  = ret_addr;
        pc         = pc_q;
        depth      = depth_q;
        fault      = fault_q;
        fault_code = fault_code_q;
    end

endmodule

// File: doc/leg_pc_ctrl.md
# leg_pc_ctrl

Program-counter and call/return controller for the 8-bit LEG core. Each accepted control operation advances, redirects, calls or returns the PC. It is the sole driver of the hardware call stack's PUSH/POP/VALUE inputs and the sole consumer of that stack's Top output. It tracks stack depth itself and traps overflow/underflow before the stack RAM is corrupted.

## Interface
Parameters:
- ADDR_W, 8, PC and stack-word width.
- STEP, 4, PC increment per sequential instruction.
- DEPTH, 256, stack capacity in entries; must match the attached stack.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset. Synchronous, active-low: rst=0 at a rising edge resets the block.
- op_valid  in  1  operation offered this cycle.
- op_ready  out  1  block accepts an operation this cycle.
- op  in  2  00 NEXT, 01 JUMP, 10 CALL, 11 RET.
- cond  in  1  condition for JUMP/CALL/RET; ignored for NEXT.
- target  in  ADDR_W  destination for JUMP/CALL.
- pc  out  ADDR_W  current program counter (registered).
- stk_push  out  1  to stack PUSH.
- stk_pop  out  1  to stack POP.
- stk_value  out  ADDR_W  to stack VALUE (return address).
- stk_top  in  ADDR_W  from stack Top (current top entry, combinational).
- depth  out  clog2(DEPTH)+1  entries currently on stack (registered).
- fault  out  1  sticky trap flag.
- fault_code  out  2  01 overflow, 10 underflow, 00 none.

## Operation
- Accept = op_valid & op_ready. With no accept, all registers hold, and stk_push = stk_pop = 0.
- taken = cond for JUMP/CALL/RET; a not-taken JUMP/CALL/RET behaves exactly as NEXT.
- ret_addr = (pc + STEP) mod 2^ADDR_W; all PC arithmetic wraps, with no carry out.
- NEXT: pc <= ret_addr.
- JUMP taken: pc <= target.
- CALL taken, depth < DEPTH: stk_push=1 and stk_value=ret_addr in the accept cycle; pc <= target; depth <= depth+1.
- CALL taken, depth == DEPTH: no push; pc holds; fault <= 1; fault_code <= 01; state <= FAULT.
- RET taken, depth > 0: stk_pop=1 in the accept cycle; pc <= stk_top sampled at that edge; depth <= depth-1; state <= RET_WAIT.
- RET taken, depth == 0: no pop; pc holds; fault <= 1; fault_code <= 10; state <= FAULT.
- stk_push and stk_pop are never both 1. Both are 0 whenever rst=0, regardless of other inputs.
- stk_value = ret_addr at all times; it is meaningful only when stk_push=1.
- FSM:
  - RUN: op_ready=1.
  - RET_WAIT: op_ready=0 for exactly one cycle, which lets the stack Top re-settle, then returns to RUN.
  - FAULT: op_ready=0, outputs frozen; leaves only via reset.
- Reset (rst=0 at edge): pc=0, depth=0, fault=0, fault_code=00, state=RUN. In the first cycle after release, op_ready=1.
- Reset mid-RET_WAIT or in FAULT returns to RUN with the reset values above. The block does not clear stack RAM contents; depth=0 makes them unreachable.

## Timing
- pc, depth, fault and fault_code update on the accept edge; their new values are visible in the next cycle.
- stk_push, stk_pop and stk_value are combinational from state, op, cond, op_valid and depth. They are asserted only during the accept cycle, so the stack updates on the same edge that updates pc.
- Throughput: one operation per cycle for NEXT/JUMP/CALL. RET costs 2 cycles (accept plus one RET_WAIT bubble).
- CALL immediately followed by RET of the same frame returns to ret_addr: the pushed value is Top in the next cycle.
- Overflow/underflow traps are detected in the accept cycle; the offending stack strobe is never asserted.

## Test plan
- Reset then 3× NEXT → pc 0,4,8,12; depth 0; no stack strobes; op_ready=1 throughout.
- pc=0x10, CALL target=0x80 cond=1 → stk_push=1 with stk_value=0x14 in that cycle; pc=0x80, depth=1. Then RET cond=1 → stk_pop=1, pc=0x14, depth=0, op_ready=0 for exactly one cycle.
- pc=0xFC, NEXT → pc=0x00 (wrap). pc=0xFC, CALL target=0x20 → pushed value 0x00.
- JUMP/CALL/RET with cond=0 at pc=0x40 → pc=0x44 each time, no strobes, depth unchanged.
- 256 CALLs, then a 257th → strobes on the first 256 only; depth=256; then fault=1, code 01, op_ready=0, pc holds. Then rst=0 for one edge → pc=0, depth=0, fault=0, op_ready=1.
- RET at depth=0 → no stk_pop, fault=1, code 10. Reset asserted during RET_WAIT → RUN with pc=0 on the next cycle.
